// File: rtl/ds1302_io.sv
// ---------------------------------------------------------------------------
// ds1302_io
// Byte-level serial engine for the DS1302 RTC 3-wire bus (CE / SCLK / SIO).
// Each accepted command runs exactly one single-byte transaction:
//   - write (cmd_addr[0]=0): command byte then data byte, 16 SCLK pulses
//   - read  (cmd_addr[0]=1): command byte then 8 returned bits, 15 SCLK pulses
// All bytes travel LSB first. The engine changes SIO only at the start of a
// low phase, and the DS1302 samples on the rising edge.
//
// Ports
//   CLK        in     system clock
//   RST        in     asynchronous reset, active-high
//   cmd_valid  in     command request
//   cmd_ready  out    engine idle; command accepted on cmd_valid & cmd_ready
//   cmd_addr   in [8] DS1302 command byte, bit0=1 read / bit0=0 write
//   cmd_wdata  in [8] write data (ignored for reads)
//   rsp_valid  out    one-cycle pulse when a transaction completes
//   rsp_rdata  out [8] last read data, held until the next read completes
//   busy       out    transaction in progress (inverse of cmd_ready)
//   CE         out    DS1302 chip enable
//   SCLK       out    DS1302 serial clock
//   SIO        inout  DS1302 data, driven only while the engine owns the bus
// ---------------------------------------------------------------------------
module ds1302_io #(
  parameter int CLK_DIV  = 25,
  parameter int CE_SETUP = 200,
  parameter int CE_HOLD  = 200
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       CE,
  output logic       SCLK,
  inout  wire        SIO
);

  // One shared counter covers the setup, half-period and hold intervals,
  // so it is sized for the largest of them.
  localparam int MAX_CE  = (CE_SETUP > CE_HOLD) ? CE_SETUP : CE_HOLD;
  localparam int CNT_MAX = (MAX_CE > CLK_DIV) ? MAX_CE : CLK_DIV;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CE_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CE_HOLD - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_CMD     = 3'd2;
  localparam logic [2:0] S_WDATA   = 3'd3;
  localparam logic [2:0] S_RDATA   = 3'd4;
  localparam logic [2:0] S_HOLD    = 3'd5;
  localparam logic [2:0] S_RECOVER = 3'd6;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             high_phase;
  logic [2:0]       bit_idx;
  logic [7:0]       addr_q;
  logic [7:0]       wdata_q;
  logic [7:0]       rdata_sh;
  logic             ce_q;
  logic             sclk_q;
  logic             sio_oe;
  logic             sio_out;
  logic [7:0]       cur_byte;
  logic             phase_done;

  // Byte currently being shifted out: command byte in CMD, data byte in WDATA.
  assign cur_byte   = (state == S_WDATA) ? wdata_q : addr_q;
  assign phase_done = (cnt == DIV_LAST);

  assign cmd_ready = (state == S_IDLE);
  assign busy      = ~cmd_ready;
  assign CE        = ce_q;
  assign SCLK      = sclk_q;
  assign SIO       = sio_oe ? sio_out : 1'bz;

  // Transaction sequencer. All bus outputs are registered so CE/SCLK/SIO
  // move together on clock edges and reset forces them idle immediately.
  // A bit slot is a low phase then a high phase of CLK_DIV cycles each;
  // the low->high and high->low transitions happen when the counter expires.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      cnt        <= '0;
      high_phase <= 1'b0;
      bit_idx    <= 3'd0;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      rdata_sh   <= 8'h00;
      ce_q       <= 1'b0;
      sclk_q     <= 1'b0;
      sio_oe     <= 1'b0;
      sio_out    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 8'h00;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            ce_q    <= 1'b1;
            sio_oe  <= 1'b1;
            sio_out <= cmd_addr[0];
            cnt     <= '0;
            state   <= S_SETUP;
          end
        end

        // CE high with SIO already presenting command bit0; the first low
        // phase of CMD keeps that same bit, so no change is needed here.
        S_SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt        <= '0;
            high_phase <= 1'b0;
            bit_idx    <= 3'd0;
            state      <= S_CMD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Outgoing bytes. At the end of each slot SCLK falls and the next bit
        // is presented; after bit7 of the command the direction is decided.
        // bit_idx wraps from 7 to 0, ready for the following byte.
        S_CMD, S_WDATA: begin
          if (!phase_done) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (!high_phase) begin
              high_phase <= 1'b1;
              sclk_q     <= 1'b1;
            end else begin
              high_phase <= 1'b0;
              sclk_q     <= 1'b0;
              bit_idx    <= bit_idx + 3'd1;
              if (bit_idx != 3'd7) begin
                sio_out <= cur_byte[bit_idx + 3'd1];
              end else if ((state == S_CMD) && !addr_q[0]) begin
                sio_out <= wdata_q[0];
                state   <= S_WDATA;
              end else if (state == S_CMD) begin
                sio_oe <= 1'b0;
                state  <= S_RDATA;
              end else begin
                sio_oe <= 1'b0;
                state  <= S_HOLD;
              end
            end
          end
        end

        // Incoming byte. The DS1302 presents each bit on a falling edge, so
        // the bit is captured at the last clock of the low phase. The eighth
        // bit has no rising edge after it; the engine goes straight to HOLD.
        S_RDATA: begin
          if (!phase_done) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (!high_phase) begin
              rdata_sh[bit_idx] <= SIO;
              if (bit_idx == 3'd7) begin
                state <= S_HOLD;
              end else begin
                high_phase <= 1'b1;
                sclk_q     <= 1'b1;
              end
            end else begin
              high_phase <= 1'b0;
              sclk_q     <= 1'b0;
              bit_idx    <= bit_idx + 3'd1;
            end
          end
        end

        // SCLK low, bus released, CE still high for one half-period so CE
        // always falls while SCLK is low.
        S_HOLD: begin
          if (phase_done) begin
            cnt   <= '0;
            ce_q  <= 1'b0;
            state <= S_RECOVER;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // CE inactive time before the next command may start. The response
        // is published on the same edge that returns the engine to idle.
        S_RECOVER: begin
          if (cnt == HOLD_LAST) begin
            cnt       <= '0;
            rsp_valid <= 1'b1;
            if (addr_q[0]) begin
              rsp_rdata <= rdata_sh;
            end
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
